// File: rtl/line_prefetcher_pkg.sv
// line_prefetcher_pkg: shared line-address types, FSM encoding and next-line helper
package line_prefetcher_pkg;
  localparam int LINE_BYTES = 32;
  localparam int OFFSET_BITS = 5;
  typedef logic [26:0] line_addr_t;
  typedef enum logic [2:0] {IDLE, HIT, FETCH, PREFETCH, WRITE} pf_state_t;
  typedef struct packed {
    logic       wrap;
    line_addr_t line;
  } next_line_t;
  function automatic next_line_t next_line(line_addr_t l);
    next_line_t n;
    n.wrap = &l;
    n.line = l + 27'd1;
    return n;
  endfunction
endpackage

// File: rtl/line_prefetcher_buffer.sv
// pf_line_buffer: single prefetched line (valid, tag, data) with load, invalidate and tag compare
module pf_line_buffer
  import line_prefetcher_pkg::*;
#(
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inval,
  input  line_addr_t            load_tag,
  input  logic [LINE_WIDTH-1:0] load_data,
  input  line_addr_t            cmp_tag,
  output logic                  hit,
  output logic [LINE_WIDTH-1:0] data
);
  logic                  valid_q, valid_d;
  line_addr_t            tag_q, tag_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  // a fill always wins; invalidation only applies to a resident line
  always_comb begin
    valid_d = load ? 1'b1 : inval ? 1'b0 : valid_q;
    tag_d   = load ? load_tag : tag_q;
    data_d  = load ? load_data : data_q;
  end
  // storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
  assign hit  = valid_q && (tag_q == cmp_tag);
  assign data = data_q;
endmodule

// File: rtl/line_prefetcher.sv
// line_prefetcher: next-line prefetcher with a one-line buffer; prefetching enabled by LINE_PREFETCH_EN
module line_prefetcher #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  import line_prefetcher_pkg::*;
  pf_state_t             state_q, state_d;
  line_addr_t            line_q, line_d;
  line_addr_t            req_line;
  next_line_t            nxt;
  logic                  pf_hit, pf_load, pf_inval, unused_ok;
  logic [LINE_WIDTH-1:0] pf_data;
  assign req_line = mem_address[ADDR_WIDTH-1:OFFSET_BITS];
  assign nxt      = next_line(line_q);
`ifdef LINE_PREFETCH_EN
  localparam bit PF = 1'b1;
  pf_line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (pf_load),
    .inval    (pf_inval),
    .load_tag (line_q),
    .load_data(pmem_rdata),
    .cmp_tag  (req_line),
    .hit      (pf_hit),
    .data     (pf_data)
  );
  assign unused_ok = ^mem_address[OFFSET_BITS-1:0];
`else
  localparam bit PF = 1'b0;
  assign pf_hit    = 1'b0;
  assign pf_data   = '0;
  assign unused_ok = ^{mem_address[OFFSET_BITS-1:0], pf_load, pf_inval};
`endif
  // line_q holds the demand line until its response, then the prefetch target
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    pf_load  = 1'b0;
    pf_inval = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
          line_d  = req_line;
          state_d = pf_hit ? HIT : FETCH;
        end else if (mem_write) begin
          line_d   = req_line;
          state_d  = WRITE;
          pf_inval = pf_hit;
        end
      end
      HIT: begin
        line_d  = nxt.line;
        state_d = nxt.wrap ? IDLE : PREFETCH;
      end
      FETCH: begin
        if (pmem_resp) begin
          line_d  = nxt.line;
          state_d = (PF && !nxt.wrap) ? PREFETCH : IDLE;
        end
      end
      PREFETCH: begin
        pf_load = pmem_resp;
        state_d = pmem_resp ? IDLE : PREFETCH;
      end
      WRITE:   state_d = pmem_resp ? IDLE : WRITE;
      default: state_d = IDLE;
    endcase
  end
  // FSM and address register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
    end
  end
  // outputs decode from state so reset deasserts everything immediately
  always_comb begin
    pmem_read    = (state_q == FETCH) || (state_q == PREFETCH);
    pmem_write   = (state_q == WRITE);
    pmem_address = (pmem_read || pmem_write) ? {line_q, {OFFSET_BITS{1'b0}}} : '0;
    pmem_wdata   = pmem_write ? mem_wdata : '0;
    mem_resp     = (state_q == HIT) || (((state_q == FETCH) || (state_q == WRITE)) && pmem_resp);
    mem_rdata    = (state_q == HIT) ? pf_data : ((state_q == FETCH) && pmem_resp) ? pmem_rdata : '0;
  end
endmodule
